// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// alu_arbiter_pkg : shared ALUop encodings and arbiter-wide constants
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_XXX  = 4'hF
  } alu_op_e;

  localparam int   PORT_ID_W         = 1;
  localparam logic PRIO_INIT_DEFAULT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ============================================================================
// alu_arbiter_alu : combinational DATA_W-bit ALU shared by the arbiter ports
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  // Undefined encodings, including ALU_XXX, deliberately yield zero.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      default:  y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : round-robin sharing of one ALU between two requesters,
//               one-entry tagged response buffer, saturating contention count
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int   DATA_W    = 32,
  parameter logic PRIO_INIT = PRIO_INIT_DEFAULT,
  parameter int   CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]  contention_cnt
);

  logic              rr_ptr;
  logic              can_accept;
  logic              both_valid;
  logic              grant_any;
  logic              grant_id;
  logic              blocked;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_y;

  // Readys are held low while reset is asserted, so nothing is accepted then.
  assign can_accept = !rst && (!rsp_valid || rsp_ready);
  assign both_valid = req0_valid && req1_valid;
  assign grant_any  = can_accept && (req0_valid || req1_valid);
  assign grant_id   = both_valid ? rr_ptr : req1_valid;

  assign req0_ready = grant_any && (grant_id == 1'b0);
  assign req1_ready = grant_any && (grant_id == 1'b1);

  assign blocked = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_XXX;
    if (req0_ready) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (req1_ready) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  alu_arbiter_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rr_ptr    <= PRIO_INIT;
    end else begin
      if (grant_any) begin
        rsp_valid <= 1'b1;
        rsp_id    <= grant_id;
        rsp_data  <= alu_y;
        if (both_valid) begin
          rr_ptr <= ~grant_id;
        end
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contention_cnt <= '0;
    end else if (blocked && (contention_cnt != {CNT_W{1'b1}})) begin
      contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
